uart_tx_cfg: RTL and testbench

Parametrised UART transmitter: next generation of the team's fixed 8E1 transmitter.
- Configurable data width at build time.
- Runtime-selectable parity (none/even/odd) and stop bits (1/2).
- valid/ready input handshake with a one-deep holding register, so back-to-back frames go out with no idle bit between them.
- Sits between a byte source (CPU register block or FIFO) and the pad. It is driven by the shared baud tick generator: one tick per bit period.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tx_cfg.sv | 129 ++++++++++++
 tb/tb_uart_tx_cfg.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, parity modes and the parity helper
// used by both the configurable transmitter and the future receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int MAX_DATA_W = 9;

  // Narrower words are zero-extended by the caller; zeros do not change the XOR.
  function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data,
                                      input logic [1:0]            mode);
    parity_bit = (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

  // Mode 2'b11 is reserved and behaves as no parity.
  function automatic logic parity_on(input logic [1:0] mode);
    parity_on = (mode != PAR_NONE) && (mode != 2'b11);
  endfunction

endpackage

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_W data bits, runtime parity and stop
// bits, valid/ready input with a one-word holding register for gapless frames.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  if (DATA_W < 5 || DATA_W > MAX_DATA_W) begin : g_bad_width
    $error("uart_tx_cfg: DATA_W must be within 5..9");
  end

  localparam logic [3:0] LAST_BIT = 4'(DATA_W);

  uart_state_e             state;
  logic                    hold_full;
  logic [DATA_W-1:0]       hold_data;
  logic [DATA_W-1:0]       shifter;
  logic [3:0]              count;
  logic                    use_par;
  logic                    par_bit;
  logic                    stop2_lat;
  logic                    stop_second;
  logic [MAX_DATA_W-1:0]   hold_ext;
  logic                    accept;
  logic                    stop_end;
  logic                    load;
  logic                    shift_en;

  always_comb begin
    hold_ext                 = '0;
    hold_ext[DATA_W-1:0]     = hold_data;
  end

  // A frame ends on the STOP tick unless the first of two stop bits is ending.
  assign stop_end = (state == ST_STOP) && !(stop2_lat && !stop_second);
  assign load     = tick && hold_full && ((state == ST_IDLE) || stop_end);
  assign accept   = tx_valid && !hold_full;
  assign shift_en = tick && ((state == ST_START) ||
                             ((state == ST_DATA) && (count < LAST_BIT)));

  assign tx_ready = !hold_full;
  assign tx_busy  = (state != ST_IDLE) || hold_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      hold_full   <= 1'b0;
      count       <= '0;
      tx          <= 1'b1;
      tx_done     <= 1'b0;
      use_par     <= 1'b0;
      par_bit     <= 1'b0;
      stop2_lat   <= 1'b0;
      stop_second <= 1'b0;
    end else begin
      tx_done <= tick && stop_end;

      if (load)        hold_full <= 1'b0;
      else if (accept) hold_full <= 1'b1;

      if (load) begin
        use_par     <= parity_on(cfg_parity);
        par_bit     <= parity_bit(hold_ext, cfg_parity);
        stop2_lat   <= cfg_stop2;
        stop_second <= 1'b0;
        count       <= '0;
        tx          <= 1'b0;
        state       <= ST_START;
      end else if (tick) begin
        case (state)
          ST_IDLE: tx <= 1'b1;
          ST_START: begin
            tx    <= shifter[0];
            count <= 4'd1;
            state <= ST_DATA;
          end
          ST_DATA: begin
            if (count < LAST_BIT) begin
              tx    <= shifter[0];
              count <= count + 4'd1;
            end else if (use_par) begin
              tx    <= par_bit;
              state <= ST_PARITY;
            end else begin
              tx    <= 1'b1;
              state <= ST_STOP;
            end
          end
          ST_PARITY: begin
            tx    <= 1'b1;
            state <= ST_STOP;
          end
          ST_STOP: begin
            tx <= 1'b1;
            if (stop2_lat && !stop_second) stop_second <= 1'b1;
            else                           state       <= ST_IDLE;
          end
          default: begin
            tx    <= 1'b1;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Word storage carries no reset; hold_full alone says whether it is valid.
  always_ff @(posedge clk) begin
    if (accept) hold_data <= tx_data;
    if (load)
      shifter <= hold_data;
    else if (shift_en)
      shifter <= shifter >> 1;
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: 8-, 5- and 9-bit builds share clock, reset,
// tick and configuration; each frame's line sequence is compared bit by bit.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [1:0] cfg_parity;
  logic       cfg_stop2;

  logic       v0, v1, v2;
  logic [7:0] d8;
  logic [4:0] d5;
  logic [8:0] d9;
  logic       rdy0, rdy1, rdy2;
  logic       tx0, tx1, tx2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;

  int         sel;
  logic       tx_s, rdy_s, busy_s, done_s;
  int         done_cnt = 0;
  int         acc_cnt  = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_W(8)) dut8 (
    .clk(clk), .rst(rst), .tick(tick), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .tx_valid(v0), .tx_ready(rdy0), .tx_data(d8), .tx(tx0), .tx_busy(busy0), .tx_done(done0));

  uart_tx_cfg #(.DATA_W(5)) dut5 (
    .clk(clk), .rst(rst), .tick(tick), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .tx_valid(v1), .tx_ready(rdy1), .tx_data(d5), .tx(tx1), .tx_busy(busy1), .tx_done(done1));

  uart_tx_cfg #(.DATA_W(9)) dut9 (
    .clk(clk), .rst(rst), .tick(tick), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .tx_valid(v2), .tx_ready(rdy2), .tx_data(d9), .tx(tx2), .tx_busy(busy2), .tx_done(done2));

  always_comb begin
    tx_s = tx0; rdy_s = rdy0; busy_s = busy0; done_s = done0;
    if (sel == 1) begin
      tx_s = tx1; rdy_s = rdy1; busy_s = busy1; done_s = done1;
    end else if (sel == 2) begin
      tx_s = tx2; rdy_s = rdy2; busy_s = busy2; done_s = done2;
    end
  end

  always @(posedge clk) begin
    if (done_s)    done_cnt <= done_cnt + 1;
    if (v0 && rdy0) acc_cnt  <= acc_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Idle for gap-1 cycles, then one single-cycle tick; returns at the
  // falling edge right after the ticked rising edge.
  task automatic pulse_tick(input int gap);
    repeat (gap - 1) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  function automatic logic [9:0] frame8n1(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  task automatic run_frame(input string tag, input int sel_i, input logic [8:0] d,
                           input logic [1:0] par, input logic st2,
                           input int gmin, input int gmax, input bit mid_cfg);
    logic [31:0] exp_b, cap;
    int          w, len, dc0;
    logic        p;
    w     = (sel_i == 1) ? 5 : (sel_i == 2) ? 9 : 8;
    exp_b = '0;
    cap   = '0;
    len   = 1;
    p     = 1'b0;
    for (int i = 0; i < w; i++) begin
      exp_b[len] = d[i];
      p          = p ^ d[i];
      len++;
    end
    if (par == 2'b01) begin
      exp_b[len] = p;  len++;
    end else if (par == 2'b10) begin
      exp_b[len] = ~p; len++;
    end
    exp_b[len] = 1'b1; len++;
    if (st2) begin
      exp_b[len] = 1'b1; len++;
    end

    sel        = sel_i;
    cfg_parity = par;
    cfg_stop2  = st2;
    if (sel_i == 1)      begin d5 = d[4:0]; v1 = 1'b1; end
    else if (sel_i == 2) begin d9 = d;      v2 = 1'b1; end
    else                 begin d8 = d[7:0]; v0 = 1'b1; end
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    check_val({tag, "_ready_low"}, rdy_s, 0);
    check_val({tag, "_busy_high"}, busy_s, 1);
    dc0 = done_cnt;
    for (int k = 0; k < len; k++) begin
      pulse_tick($urandom_range(gmin, gmax));
      cap[k] = tx_s;
      if (mid_cfg && k == 2) begin
        cfg_parity = 2'b10;
        cfg_stop2  = ~st2;
      end
    end
    check_val({tag, "_bits"}, cap, exp_b);
    check_val({tag, "_no_early_done"}, done_cnt - dc0, 0);
    pulse_tick(gmin);
    check_val({tag, "_done"}, done_s, 1);
    check_val({tag, "_idle_line"}, tx_s, 1);
    @(negedge clk);
    check_val({tag, "_busy_low"}, busy_s, 0);
    check_val({tag, "_ready_high"}, rdy_s, 1);
    check_val({tag, "_done_count"}, done_cnt - dc0, 1);
  endtask

  initial begin
    logic [31:0] exp_b, cap;
    int          dc0, ac0;

    rst = 1'b1; tick = 1'b0; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; d8 = '0; d5 = '0; d9 = '0; sel = 0;
    repeat (2) @(negedge clk);
    check_val("reset_tx", tx0, 1);
    check_val("reset_ready", rdy0, 1);
    check_val("reset_busy", busy0, 0);
    check_val("reset_done", done0, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_frame("n1_55",      0, 9'h055, 2'b00, 1'b0, 3, 3,  1'b0);
    run_frame("e1_55",      0, 9'h055, 2'b01, 1'b0, 3, 3,  1'b0);
    run_frame("o1_00",      0, 9'h000, 2'b10, 1'b0, 2, 2,  1'b0);
    run_frame("n2_ff",      0, 9'h0FF, 2'b00, 1'b1, 3, 3,  1'b0);
    run_frame("e2_ff",      0, 9'h0FF, 2'b01, 1'b1, 2, 5,  1'b0);
    run_frame("p11_3c",     0, 9'h03C, 2'b11, 1'b0, 3, 3,  1'b0);
    run_frame("midcfg_a7",  0, 9'h0A7, 2'b00, 1'b0, 3, 3,  1'b1);
    run_frame("rnd_55",     0, 9'h055, 2'b00, 1'b0, 2, 20, 1'b0);
    run_frame("w5_o1_1f",   1, 9'h01F, 2'b10, 1'b0, 2, 20, 1'b0);
    run_frame("w9_o1_1ab",  2, 9'h1AB, 2'b10, 1'b0, 2, 20, 1'b0);
    run_frame("w9_e2_100",  2, 9'h100, 2'b01, 1'b1, 3, 3,  1'b0);

    // Three words back to back; the third waits while the holding register is full.
    sel = 0; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    exp_b = {2'b00, frame8n1(8'h96), frame8n1(8'h3C), frame8n1(8'hA5)};
    cap = '0;
    dc0 = done_cnt;
    ac0 = acc_cnt;
    v0 = 1'b1; d8 = 8'hA5;
    @(negedge clk);
    d8 = 8'h3C;
    for (int k = 0; k < 30; k++) begin
      pulse_tick(3);
      cap[k] = tx0;
      if (k == 5) check_val("b2b_held_not_ready", rdy0, 0);
      if (k == 0 || k == 10) begin
        check_val("b2b_ready_after_load", rdy0, 1);
        @(negedge clk);
        check_val("b2b_ready_after_accept", rdy0, 0);
        if (k == 0) d8 = 8'h96;
        else        v0 = 1'b0;
      end
    end
    check_val("b2b_bits", cap, exp_b);
    pulse_tick(3);
    @(negedge clk);
    check_val("b2b_done_count", done_cnt - dc0, 3);
    check_val("b2b_accepts", acc_cnt - ac0, 3);
    check_val("b2b_busy_low", busy0, 0);

    // Asynchronous reset in the middle of data bit 3 with a second word held.
    cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    v0 = 1'b1; d8 = 8'hC3;
    @(negedge clk);
    v0 = 1'b0;
    pulse_tick(3);
    v0 = 1'b1; d8 = 8'h0F;
    @(negedge clk);
    v0 = 1'b0;
    for (int k = 1; k < 5; k++) pulse_tick(3);
    dc0 = done_cnt;
    check_val("rst_pre_tx_d3", tx0, 0);
    check_val("rst_pre_ready", rdy0, 0);
    #2 rst = 1'b1;
    #1;
    check_val("rst_async_tx", tx0, 1);
    check_val("rst_async_ready", rdy0, 1);
    check_val("rst_async_busy", busy0, 0);
    check_val("rst_async_done", done0, 0);
    @(negedge clk);
    rst = 1'b0;
    cap = '0;
    for (int k = 0; k < 12; k++) begin
      pulse_tick(3);
      cap[k] = tx0;
    end
    check_val("rst_line_stays_idle", cap, 32'h0000_0FFF);
    check_val("rst_held_word_dropped", busy0, 0);
    check_val("rst_no_done", done_cnt - dc0, 0);
    run_frame("post_rst_5a", 0, 9'h05A, 2'b00, 1'b0, 3, 3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
